avalon_onchip_ram_pipelined: RTL

- Parametrised Avalon-MM slave on-chip RAM; successor to the fixed 32-bit/10240-word single-port SRAM in the system Qsys build.
- Adds configurable width, depth and read latency.
- Adds readdatavalid/waitrequest handshake, byte-merged read-during-write forwarding, out-of-range protection and a post-reset memory clear sequencer.
- Sits on the system interconnect as a data/scratch memory for the Nios core and DMA.

---
 rtl/avalon_onchip_ram_pipelined.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/avalon_onchip_ram_pipelined.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : avalon_onchip_ram_pipelined                                   |
// | Purpose  : Avalon-MM slave on-chip RAM with byte enables, 1- or 2-cycle  |
// |            pipelined reads, read-during-write forwarding, out-of-range   |
// |            protection and an optional post-reset clear sequencer.        |
// | Option   : `define ONCHIP_RAM_CLEAR_EN builds the clear sequencer; when  |
// |            undefined the array is preloaded from INIT_FILE instead.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module avalon_onchip_ram_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int DEPTH        = 10240,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "system_SRAM.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done
);

  localparam int                  NUM_BYTES = DATA_WIDTH / 8;
  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,   // clearing (or one post-reset cycle when no clear)
    ST_READY = 1'b1
  } state_t;

  state_t state;

`ifdef ONCHIP_RAM_CLEAR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  logic [IDX_W-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
`else
  // Contents come from INIT_FILE through the FPGA memory-init attribute.
  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];
`endif

  logic                  accept;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rdv_q;

  assign waitrequest = (state != ST_READY) | ~clken;
  assign accept      = chipselect & (read | write) & ~waitrequest;
  assign wr_accept   = accept & write;
  assign rd_accept   = accept & read & ~write;   // write wins a combined request
  assign in_range    = {1'b0, address} < DEPTH_W;
  assign idx         = address[IDX_W-1:0];
  assign rd_word     = in_range ? mem[idx] : '0;  // out-of-range reads return zero

  assign readdatavalid = rdv_q & clken;           // a held pulse is shown once clken returns

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_BYTES-1:0]  be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Control FSM: post-reset init (optionally clearing every word), then ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      init_done <= 1'b0;
`ifdef ONCHIP_RAM_CLEAR_EN
      clr_addr  <= '0;
`endif
    end else if (clken) begin
      case (state)
        ST_INIT: begin
`ifdef ONCHIP_RAM_CLEAR_EN
          if (clr_addr == LAST_IDX) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
`else
          state     <= ST_READY;
          init_done <= 1'b1;
`endif
        end
        default: begin
          state     <= ST_READY;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: zero fill during clear, byte-enabled writes when ready.
  always_ff @(posedge clk) begin
    if (!reset && clken) begin
`ifdef ONCHIP_RAM_CLEAR_EN
      if (state == ST_INIT) begin
        mem[clr_addr] <= '0;
      end else if (wr_accept && in_range) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
`else
      if (wr_accept && in_range) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
`endif
    end
  end

  if (READ_LATENCY == 1) begin : g_rl1
    // Single-stage read: array word registered straight onto readdata.
    always_ff @(posedge clk) begin
      if (reset) begin
        rdv_q    <= 1'b0;
        readdata <= '0;
      end else if (clken) begin
        rdv_q <= rd_accept;
        if (rd_accept) readdata <= rd_word;
      end
    end
  end else begin : g_rl2
    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  wr_hit;

    // A write landing while the read sits in stage 1 must show up in its data.
    assign wr_hit = wr_accept & in_range & (address == s1_addr);

    // Two-stage read: capture word, then merge any same-address write and emit.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid <= 1'b0;
        s1_addr  <= '0;
        s1_data  <= '0;
        rdv_q    <= 1'b0;
        readdata <= '0;
      end else if (clken) begin
        s1_valid <= rd_accept;
        if (rd_accept) begin
          s1_addr <= address;
          s1_data <= rd_word;
        end
        rdv_q <= s1_valid;
        if (s1_valid) begin
          readdata <= wr_hit ? byte_merge(s1_data, writedata, byteenable) : s1_data;
        end
      end
    end
  end

endmodule
`default_nettype wire
